// File: rtl/sum_display_pkg.sv
// Shared types and constants for the sum display stage: FSM states, segment codes,
// and one double-dabble step.
package sum_display_pkg;

   typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

   localparam int CONV_ITERS = 5;

   // Active-low segment codes {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_B     = 7'b0000011;
   localparam logic [6:0] SEG_C     = 7'b1000110;
   localparam logic [6:0] SEG_D     = 7'b0100001;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_F     = 7'b0001110;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Layout {tens[3:0], units[3:0], bin[4:0]}; add-3 correction then shift left.
   function automatic logic [12:0] dd_step(input logic [12:0] v);
      logic [12:0] t;
      t = v;
      if (t[12:9] >= 4'd5) t[12:9] = t[12:9] + 4'd3;
      if (t[8:5]  >= 4'd5) t[8:5]  = t[8:5]  + 4'd3;
      return {t[11:0], 1'b0};
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex digit to active-low seven-segment code.
module seg7_decode
   import sum_display_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (digit)
         4'h0: seg = SEG_0;
         4'h1: seg = SEG_1;
         4'h2: seg = SEG_2;
         4'h3: seg = SEG_3;
         4'h4: seg = SEG_4;
         4'h5: seg = SEG_5;
         4'h6: seg = SEG_6;
         4'h7: seg = SEG_7;
         4'h8: seg = SEG_8;
         4'h9: seg = SEG_9;
         4'hA: seg = SEG_A;
         4'hB: seg = SEG_B;
         4'hC: seg = SEG_C;
         4'hD: seg = SEG_D;
         4'hE: seg = SEG_E;
         4'hF: seg = SEG_F;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/sum_display_scan.sv
// Captures the adder result and scans it onto a two-digit active-low display.
// SUM_DISPLAY_DECIMAL_EN selects decimal (double-dabble FSM); otherwise hex display.
module sum_display_scan
   import sum_display_pkg::*;
#(
   parameter int REFRESH_DIV = 50000
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [3:0] d,
   input  logic [3:0] cout,
   output logic [4:0] sum_q,
   output logic       busy,
   output logic [6:0] seg,
   output logic [1:0] an
);

   localparam int CW = $clog2(REFRESH_DIV);

   logic [CW-1:0] rcnt, rcnt_nxt;
   logic          sel, sel_nxt;
   logic [3:0]    tens_q, units_q, tens_d, units_d;
   logic [6:0]    seg_nxt;
   logic          unused_cout;

   assign unused_cout = ^cout[3:1];

`ifdef SUM_DISPLAY_DECIMAL_EN
   state_t      state;
   logic [2:0]  iter;
   logic [12:0] dd;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         sum_q <= '0;
         busy  <= 1'b0;
         iter  <= '0;
         dd    <= '0;
      end else begin
         case (state)
            IDLE: if (load) begin
               sum_q <= {cout[0], d};
               dd    <= {8'h00, cout[0], d};
               iter  <= 3'(CONV_ITERS);
               busy  <= 1'b1;
               state <= CONVERT;
            end
            CONVERT: begin
               dd   <= dd_step(dd);
               iter <= iter - 3'd1;
               if (iter == 3'd1) state <= DONE;
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      tens_d  = tens_q;
      units_d = units_q;
      if (state == DONE) begin
         tens_d  = dd[12:9];
         units_d = dd[8:5];
      end
   end
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    sum_q <= '0;
      else if (load) sum_q <= {cout[0], d};
   end

   assign busy = 1'b0;

   always_comb begin
      tens_d  = tens_q;
      units_d = units_q;
      if (load) begin
         tens_d  = {3'b000, cout[0]};
         units_d = d;
      end
   end
`endif

   // Decode from next-state digits so a digit update reaches seg on the same edge.
   assign rcnt_nxt = (rcnt == CW'(REFRESH_DIV - 1)) ? '0 : rcnt + 1'b1;
   assign sel_nxt  = (rcnt == CW'(REFRESH_DIV - 1)) ? ~sel : sel;

   seg7_decode u_dec (
      .digit (sel_nxt ? tens_d : units_d),
      .seg   (seg_nxt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rcnt    <= '0;
         sel     <= 1'b0;
         tens_q  <= '0;
         units_q <= '0;
         seg     <= SEG_BLANK;
         an      <= 2'b11;
      end else begin
         rcnt    <= rcnt_nxt;
         sel     <= sel_nxt;
         tens_q  <= tens_d;
         units_q <= units_d;
         seg     <= seg_nxt;
         an      <= sel_nxt ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: tb/tb_sum_display_scan.sv
// Randomized bench for sum_display_scan against a cycle-count based display model,
// plus directed literal checks for the selected build.
module tb_sum_display_scan;

   localparam int R = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       load = 1'b0;
   logic [3:0] d = '0;
   logic [3:0] cout = '0;
   logic [4:0] sum_q;
   logic       busy;
   logic [6:0] seg;
   logic [1:0] an;

   int checks = 0;
   int errors = 0;
   bit go = 1'b0;

   logic [6:0] segtab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   sum_display_scan #(.REFRESH_DIV(R)) dut (
      .clk(clk), .rst_n(rst_n), .load(load), .d(d), .cout(cout),
      .sum_q(sum_q), .busy(busy), .seg(seg), .an(an)
   );

   always #5 clk = ~clk;

   // Model: k = edges since reset release; digit slot = (k/R) mod 2.
   int k, msum, mtens, munits, pend;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k = 0; msum = 0; mtens = 0; munits = 0; pend = 0;
      end else begin
         k++;
`ifdef SUM_DISPLAY_DECIMAL_EN
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               mtens  = msum / 10;
               munits = msum % 10;
            end
         end else if (load) begin
            msum = 16 * int'(cout[0]) + int'(d);
            pend = 6;
         end
`else
         if (load) begin
            msum   = 16 * int'(cout[0]) + int'(d);
            mtens  = int'(cout[0]);
            munits = int'(d);
         end
`endif
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (go) begin
         int slot;
         slot = (k / R) % 2;
         chk("sum_q", int'(sum_q), msum);
         chk("busy", int'(busy), int'(pend > 0));
         chk("an", int'(an), (k == 0) ? 2'b11 : (slot == 1 ? 2'b01 : 2'b10));
         chk("seg", int'(seg), (k == 0) ? 7'h7F : int'(segtab[slot == 1 ? mtens : munits]));
      end
   end

   task automatic do_load(input logic [3:0] dv, input logic [3:0] cv);
      @(negedge clk);
      load = 1'b1; d = dv; cout = cv;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic wait_an(input logic [1:0] v, input string nm);
      int n = 0;
      while (an !== v && n < 4 * R + 4) begin
         @(negedge clk);
         n++;
      end
      if (an !== v) chk({nm, "_timeout"}, int'(an), int'(v));
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy !== 1'b0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("idle_timeout", int'(busy), 0);
   endtask

   task automatic show(input int tens_code, input int units_code, input string nm);
      wait_an(2'b10, nm);
      chk({nm, "_units"}, int'(seg), units_code);
      wait_an(2'b01, nm);
      chk({nm, "_tens"}, int'(seg), tens_code);
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #1 go = 1'b1;
      chk("rst_seg", int'(seg), 7'h7F);
      chk("rst_an", int'(an), 2'b11);
      chk("rst_busy", int'(busy), 0);
      chk("rst_sum", int'(sum_q), 0);
      @(negedge clk); @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("first_an", int'(an), 2'b10);

      // Scan cadence: each completed run of a select value lasts R cycles.
      begin
         logic [1:0] prev;
         int run = 0, nruns = 0;
         prev = an;
         for (int i = 0; i < 8 * R; i++) begin
            @(negedge clk);
            if (an == 2'b00) chk("an_both_on", int'(an), 2'b10);
            if (an != prev) begin
               if (nruns > 0) chk("scan_run", run + 1, R);
               nruns++;
               run = 0;
               prev = an;
            end else run++;
         end
      end

`ifdef SUM_DISPLAY_DECIMAL_EN
      begin
         int nb = 0;
         do_load(4'd15, 4'd0);
         chk("sum15", int'(sum_q), 15);
         while (busy === 1'b1 && nb < 20) begin
            nb++;
            @(negedge clk);
         end
         chk("busy_len", nb, 6);
         chk("model_15", 10 * mtens + munits, 15);
         show(7'b1111001, 7'b0010010, "dec15");
      end
      do_load(4'd14, 4'b0001);
      chk("sum30", int'(sum_q), 30);
      wait_idle();
      show(7'b0110000, 7'b1000000, "dec30");

      do_load(4'd15, 4'd0);
      @(negedge clk);
      do_load(4'd8, 4'd0);
      chk("ignored_sum", int'(sum_q), 15);
      wait_idle();
      chk("ignored_sum_end", int'(sum_q), 15);
      show(7'b1111001, 7'b0010010, "ignored");

      do_load(4'd9, 4'd1);
      @(posedge clk); @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_seg", int'(seg), 7'h7F);
      chk("midrst_an", int'(an), 2'b11);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_sum", int'(sum_q), 0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      show(7'b1000000, 7'b1000000, "after_rst");
`else
      do_load(4'd15, 4'd0);
      chk("hex_busy", int'(busy), 0);
      chk("hex_sum15", int'(sum_q), 15);
      chk("model_hexF", munits, 15);
      show(7'b1000000, 7'b0001110, "hex0F");
      do_load(4'd14, 4'b1011);
      chk("hex_sum30", int'(sum_q), 30);
      show(7'b1111001, 7'b0000110, "hex1E");

      do_load(4'd5, 4'd1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_seg", int'(seg), 7'h7F);
      chk("midrst_an", int'(an), 2'b11);
      chk("midrst_sum", int'(sum_q), 0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      show(7'b1000000, 7'b1000000, "after_rst");
`endif

      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         load = ($urandom_range(0, 4) == 0);
         d    = 4'($urandom);
         cout = 4'($urandom);
         if ($urandom_range(0, 150) == 0) begin
            load = 1'b0;
            #2 rst_n = 1'b0;
            @(negedge clk);
            #2 rst_n = 1'b1;
         end
      end
      @(negedge clk);
      load = 1'b0;
      repeat (3 * R) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
